// File: rtl/psg_ctl_pkg.sv
`default_nettype none
// ============================================================================
// psg_ctl_pkg : shared types and constants for the TurboSound bus arbiter
// Rev 1.0
// ============================================================================
package psg_ctl_pkg;

    typedef enum logic {
        OP_ADDR = 1'b0,
        OP_DATA = 1'b1
    } op_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_ADR  = 3'd2,
        ST_DAT  = 3'd3,
        ST_RD   = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SRC_CPU_WR = 2'd0,
        SRC_CPU_RD = 2'd1,
        SRC_LD     = 2'd2
    } src_e;

    typedef struct packed {
        op_kind_e   kind;
        logic [7:0] data;
    } cmd_t;

    localparam logic [7:0] SEL_AY0 = 8'hFE;
    localparam logic [7:0] SEL_AY1 = 8'hFF;

    // First bus state needed to reach {chip_tgt, reg_tgt} from the latched context.
    function automatic state_e next_bus_state(
        input logic       chip_vld,
        input logic       chip_cur,
        input logic       reg_vld,
        input logic [7:0] reg_cur,
        input logic       chip_tgt,
        input logic [7:0] reg_tgt,
        input logic       is_rd
    );
        if (!chip_vld || (chip_cur != chip_tgt)) return ST_SEL;
        if (!reg_vld || (reg_cur != reg_tgt))    return ST_ADR;
        return is_rd ? ST_RD : ST_DAT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psg_cmd_fifo.sv
`default_nettype none
// ============================================================================
// psg_cmd_fifo : synchronous FIFO queueing CPU port writes for the arbiter
// Rev 1.0
// ============================================================================
module psg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/psg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// psg_bus_arbiter : shares the TurboSound BDIR/BC bus between Z80 and loader
// Rev 1.0
// ============================================================================
module psg_bus_arbiter
    import psg_ctl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE,
    input  logic       cpu_addr_wr,
    input  logic       cpu_data_wr,
    input  logic [7:0] cpu_di,
    input  logic       cpu_rd,
    output logic [7:0] cpu_do,
    output logic       cpu_wait,
    output logic       fifo_ovf,
    input  logic       ld_req,
    input  logic       ld_chip,
    input  logic [3:0] ld_reg,
    input  logic [7:0] ld_data,
    output logic       ld_ack,
    output logic       psg_bdir,
    output logic       psg_bc,
    output logic [7:0] psg_di,
    input  logic [7:0] psg_do,
    output logic       busy
);
    localparam int CMD_W = $bits(cmd_t);

    state_e           r_state;
    state_e           w_state_nxt;
    state_e           w_route;
    src_e             r_src;
    src_e             w_src;
    logic             r_txn_done;
    logic             r_sh_chip;
    logic [7:0]       r_sh_reg;
    logic             r_ctx_chip_vld;
    logic             r_ctx_chip;
    logic             r_ctx_reg_vld;
    logic [7:0]       r_ctx_reg;
    logic [7:0]       r_psg_di;
    logic [7:0]       w_di_nxt;
    logic [7:0]       r_cpu_do;
    logic             r_rd_done;
    logic             r_ld_ack;
    logic             r_fifo_ovf;
    logic             w_start;
    logic             w_pop_addr;
    logic             w_pop;
    logic             w_push;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CMD_W-1:0] w_head_raw;
    cmd_t             w_head;
    cmd_t             w_push_cmd;
    logic             w_tgt_chip;
    logic [7:0]       w_tgt_reg;
    logic [7:0]       w_tgt_data;
    logic             w_bus_done;

    // A simultaneous addr+data strobe keeps only the address write.
    assign w_push = cpu_addr_wr | cpu_data_wr;

    always_comb begin
        w_push_cmd.kind = cpu_addr_wr ? OP_ADDR : OP_DATA;
        w_push_cmd.data = cpu_di;
    end

    psg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (w_push),
        .din     (w_push_cmd),
        .pop     (w_pop),
        .dout    (w_head_raw),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign w_head = cmd_t'(w_head_raw);

    always_comb begin
        w_start    = 1'b0;
        w_pop_addr = 1'b0;
        w_src      = r_src;
        if (r_state == ST_IDLE) begin
            if (!w_fifo_empty) begin
                if (w_head.kind == OP_ADDR) begin
                    w_pop_addr = 1'b1;
                end else begin
                    w_src   = SRC_CPU_WR;
                    w_start = 1'b1;
                end
            end else if (cpu_rd && !r_rd_done) begin
                w_src   = SRC_CPU_RD;
                w_start = 1'b1;
            end else if (ld_req) begin
                w_src   = SRC_LD;
                w_start = 1'b1;
            end
        end
    end

    always_comb begin
        w_tgt_chip = r_sh_chip;
        w_tgt_reg  = r_sh_reg;
        w_tgt_data = w_head.data;
        if (w_src == SRC_LD) begin
            w_tgt_chip = ld_chip;
            w_tgt_reg  = {4'h0, ld_reg};
            w_tgt_data = ld_data;
        end
    end

    assign w_route = next_bus_state(r_ctx_chip_vld, r_ctx_chip, r_ctx_reg_vld, r_ctx_reg,
                                    w_tgt_chip, w_tgt_reg, w_src == SRC_CPU_RD);
    assign w_bus_done = CE && (r_state inside {ST_SEL, ST_ADR, ST_DAT, ST_RD});
    assign w_pop = w_pop_addr || (r_state == ST_DAT && CE && r_src == SRC_CPU_WR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:                      if (w_start) w_state_nxt = w_route;
            ST_SEL, ST_ADR, ST_DAT, ST_RD: if (CE) w_state_nxt = ST_GAP;
            ST_GAP:                       w_state_nxt = r_txn_done ? ST_IDLE : w_route;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // DI is loaded for the upcoming bus state and otherwise held, so GAP keeps the old value.
    always_comb begin
        w_di_nxt = r_psg_di;
        case (w_state_nxt)
            ST_SEL:  w_di_nxt = w_tgt_chip ? SEL_AY1 : SEL_AY0;
            ST_ADR:  w_di_nxt = w_tgt_reg;
            ST_DAT:  w_di_nxt = w_tgt_data;
            default: w_di_nxt = r_psg_di;
        endcase
    end

    always_comb begin
        psg_bdir = 1'b0;
        psg_bc   = 1'b0;
        case (r_state)
            ST_SEL, ST_ADR: begin
                psg_bdir = 1'b1;
                psg_bc   = 1'b1;
            end
            ST_DAT:  psg_bdir = 1'b1;
            ST_RD:   psg_bc   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= ST_IDLE;
            r_src          <= SRC_CPU_WR;
            r_txn_done     <= 1'b0;
            r_sh_chip      <= 1'b1;
            r_sh_reg       <= 8'h00;
            r_ctx_chip_vld <= 1'b0;
            r_ctx_chip     <= 1'b0;
            r_ctx_reg_vld  <= 1'b0;
            r_ctx_reg      <= 8'h00;
            r_psg_di       <= 8'h00;
            r_cpu_do       <= 8'h00;
            r_rd_done      <= 1'b0;
            r_ld_ack       <= 1'b0;
            r_fifo_ovf     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_psg_di <= w_di_nxt;
            if (w_start) begin
                r_src      <= w_src;
                r_txn_done <= 1'b0;
            end
            if (w_bus_done && (r_state == ST_DAT || r_state == ST_RD)) r_txn_done <= 1'b1;
            // SEL also latches 0xFE/0xFF as the address inside the chip.
            if (w_bus_done && r_state == ST_SEL) begin
                r_ctx_chip_vld <= 1'b1;
                r_ctx_chip     <= w_tgt_chip;
                r_ctx_reg_vld  <= 1'b0;
            end
            if (w_bus_done && r_state == ST_ADR) begin
                r_ctx_reg_vld <= 1'b1;
                r_ctx_reg     <= w_tgt_reg;
            end
            if (w_pop_addr) begin
                if (w_head.data[7:1] == SEL_AY0[7:1]) r_sh_chip <= w_head.data[0];
                else                                   r_sh_reg  <= w_head.data;
            end
            if (w_bus_done && r_state == ST_RD) begin
                r_cpu_do  <= psg_do;
                r_rd_done <= 1'b1;
            end else if (!cpu_rd) begin
                r_rd_done <= 1'b0;
            end
            r_ld_ack <= w_bus_done && (r_state == ST_DAT) && (r_src == SRC_LD);
            if ((cpu_addr_wr && cpu_data_wr) || (w_push && w_fifo_full)) r_fifo_ovf <= 1'b1;
        end
    end

    assign psg_di   = r_psg_di;
    assign cpu_do   = r_cpu_do;
    assign cpu_wait = cpu_rd & ~r_rd_done;
    assign fifo_ovf = r_fifo_ovf;
    assign ld_ack   = r_ld_ack;
    assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: doc/psg_bus_arbiter.md
# psg_bus_arbiter

Shares the TurboSound PSG bus (BDIR/BC/DI/DO) between two requesters: the Z80 port interface (address/data writes to 0xFFFD/0xBFFD, reads from 0xFFFD) and a hardware register loader (snapshot restore / menu mute). It sits directly in front of the turbosound instance. It owns all BDIR/BC sequencing and tracks which AY chip and register are currently latched on the bus. After a loader access, it lazily restores the CPU's chip and register context so the CPU never sees the interleaving.

## Interface
- FIFO_DEPTH, 4, CPU write queue depth (power of 2, ≥2)
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- CE  in  1  PSG clock enable (same strobe fed to turbosound CE)
- cpu_addr_wr  in  1  single-cycle strobe: OUT to 0xFFFD, value on cpu_di
- cpu_data_wr  in  1  single-cycle strobe: OUT to 0xBFFD, value on cpu_di
- cpu_di  in  8  CPU write data
- cpu_rd  in  1  level: IN from 0xFFFD pending; held until cpu_wait falls
- cpu_do  out  8  registered read data, valid when cpu_rd=1 and cpu_wait=0
- cpu_wait  out  1  Z80 WAIT request: cpu_rd & ~rd_done (combinational)
- fifo_ovf  out  1  sticky: a CPU write was dropped
- ld_req  in  1  loader request; ld_* held stable until ld_ack
- ld_chip  in  1  target AY (0/1)
- ld_reg  in  4  target register
- ld_data  in  8  value
- ld_ack  out  1  one-cycle pulse: loader write complete
- psg_bdir, psg_bc  out  1 each  to turbosound BDIR/BC
- psg_di  out  8  to turbosound DI
- psg_do  in  8  from turbosound DO
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- Reset values: all outputs 0. FIFO empty. CPU shadow is chip=1, reg=0. Bus context is invalid. rd_done=0.
- CPU writes are enqueued as {kind, data}.
  - Write while FIFO full: dropped, fifo_ovf=1.
  - cpu_addr_wr and cpu_data_wr in the same cycle: addr enqueued, data dropped, fifo_ovf=1.
- IDLE priority: FIFO head > cpu_rd (only when FIFO empty and ~rd_done) > ld_req.
- FIFO ADDR entry: no bus op; one cycle, pops.
  - Value 0xFE/0xFF updates the CPU shadow chip (value[0]).
  - Any other value updates the CPU shadow reg (8 bits).
- Before a CPU DATA or READ:
  - If the bus context is invalid or bus chip ≠ shadow chip → SEL state (address write of 0xFE|chip).
  - If the bus reg ≠ shadow reg (or invalid) → ADR state (address write of reg).
  - Then DAT (BDIR=1, BC=0, DI=data; pop on completion) or RD (BDIR=0, BC=1; capture psg_do into cpu_do at completion, set rd_done).
- rd_done clears the cycle after cpu_rd is seen low.
- Loader: same SEL/ADR elision against {ld_chip, zero-extended ld_reg}, then DAT, then ld_ack in the following GAP cycle.
- The bus context updates on completion of each SEL/ADR. Every SEL also latches address 0xFE/0xFF in the newly selected chip, so the bus reg is invalidated after SEL and ADR always follows.
- States: IDLE, SEL, ADR, DAT, RD, GAP. Every bus state → GAP → next required state or IDLE.

## Timing
- A bus state drives BDIR/BC/DI from entry and holds through the first cycle with CE=1 inclusive. If CE=1 on the entry cycle, the state lasts one cycle.
- GAP: BDIR=BC=0 for exactly one cycle; psg_di holds its last value.
- CPU data write latency (idle arbiter, context match): strobe in cycle t → psg_bdir=1 from cycle t+2.
- cpu_do updates on the same edge that sets rd_done. cpu_wait falls the following cycle.
- A loader transaction (SEL, ADR, DAT) is atomic. CPU strobes arriving meanwhile queue; cpu_rd waits.
- Async reset mid-transaction: outputs go to 0 immediately, the transaction is abandoned, and no ld_ack is issued.

## Structure
- Package psg_ctl_pkg holds:
  - op-kind enum (OP_ADDR, OP_DATA)
  - state enum
  - constants SEL_AY0=8'hFE, SEL_AY1=8'hFF
- Sub-module psg_cmd_fifo: synchronous FIFO with push/pop/full/empty, depth from FIFO_DEPTH, async active-low reset.

## Test plan
- After reset, CPU addr_wr 0x07 then data_wr 0x38 → SEL(0xFF), ADR(0x07), DAT(0x38) with a GAP between each. No ops are elided, since the context starts invalid.
- A second data_wr 0x3F → DAT only, with psg_bdir=1 two cycles after the strobe (CE tied high).
- Loader chip0/reg8/0x0F, then CPU data_wr 0x10 → SEL(0xFE), ADR(0x08), DAT(0x0F), ld_ack, then SEL(0xFF), ADR(0x07), DAT(0x10).
- cpu_rd with psg_do=0x5A and CE every 4th cycle → cpu_wait high until capture, cpu_do=0x5A. BDIR/BC=0/1 held until the CE cycle.
- Five CPU writes in consecutive cycles while a loader op is stalled by CE=0 → four queued and one dropped, fifo_ovf=1. The queued writes drain in order afterwards.
- RESET_N low during the ADR phase of a loader op → bus signals 0 at once and no ld_ack. After release, the next op starts with SEL.
